// File: rtl/fifo_rd_pkg.sv
// Shared constants and width helpers for the line-buffer FIFO read adapter.
// Width helpers are functions because the real depths come from module
// parameters. The localparams below give the widths for the default build.
// No ports; imported by fifo_rd_adapt_buf and fifo_line_buffer_rd_adapter.
package fifo_rd_pkg;

  localparam int unsigned STATS_W        = 32;
  localparam int unsigned DEF_RD_LATENCY = 1;
  localparam int unsigned DEF_IMG_WIDTH  = 640;
  localparam int unsigned DEF_IMG_HEIGHT = 480;

  // Bits needed to index n entries (at least 1).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold a count of 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // The output buffer covers the full read latency plus two slots.
  function automatic int unsigned buf_depth(input int unsigned rd_latency);
    return rd_latency + 2;
  endfunction

  localparam int unsigned BUF_DEPTH_DEF = buf_depth(DEF_RD_LATENCY);
  localparam int unsigned BUF_IDX_W     = idx_w(BUF_DEPTH_DEF);
  localparam int unsigned BUF_CNT_W     = cnt_w(BUF_DEPTH_DEF);
  localparam int unsigned COL_W         = idx_w(DEF_IMG_WIDTH);
  localparam int unsigned ROW_W         = idx_w(DEF_IMG_HEIGHT);

endpackage

// File: rtl/fifo_rd_adapt_buf.sv
// Circular output buffer for the FIFO read adapter.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push_i        write push_data_i at the tail (caller guarantees space)
//   pop_i         drop the head entry (ignored while empty)
//   head_o        head entry, 0 while empty
//   count_o       number of stored entries
module fifo_rd_adapt_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = BUF_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   head_o,
  output logic [cnt_w(DEPTH)-1:0] count_o
);

  localparam int unsigned IW = idx_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IW-1:0]         wr_q, wr_d;
  logic [IW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_pop;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
  endfunction

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    wr_d    = push_i ? wrap_inc(wr_q) : wr_q;
    rd_d    = do_pop ? wrap_inc(rd_q) : rd_q;
    count_d = count_q;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: head_o is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fifo_line_buffer_rd_adapter.sv
// Read-side adapter between the 1-bit line-buffer FIFO/RAM pair and the
// morphology window logic. Issues reads only when a buffer slot is reserved,
// absorbs the RAM read latency, and presents a first-word-fall-through
// valid/ready stream tagged with start-of-frame and end-of-line.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fifo_rempty         registered empty flag from the FIFO controller
//   fifo_r_en           read request (combinational)
//   fifo_rdata          RAM data, valid RD_LATENCY cycles after an accepted read
//   m_valid/m_ready     output handshake
//   m_data, m_sof, m_eol  head pixel and its position markers
// Optional build macro FIFO_RD_ADAPT_STATS_EN adds saturating stall_cnt and
// starve_cnt outputs.
module fifo_line_buffer_rd_adapter
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY,
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_rempty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol
`ifdef FIFO_RD_ADAPT_STATS_EN
  ,
  output logic [STATS_W-1:0]    stall_cnt,
  output logic [STATS_W-1:0]    starve_cnt
`endif
);

  localparam int unsigned BUF_DEPTH = buf_depth(RD_LATENCY);
  localparam int unsigned BCW       = cnt_w(BUF_DEPTH);
  localparam int unsigned SW        = cnt_w(2 * BUF_DEPTH);
  localparam int unsigned CLW       = idx_w(IMG_WIDTH);
  localparam int unsigned RWW       = idx_w(IMG_HEIGHT);

  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [BCW-1:0]        buf_count;
  logic [SW-1:0]         inflight;
  logic [SW-1:0]         occupancy;
  logic [CLW-1:0]        col_q, col_d;
  logic [RWW-1:0]        row_q, row_d;
  logic                  accepted_rd;
  logic                  push;
  logic                  pop;

  // Slots are reserved for every read still in the pipe, so the buffer can
  // never overflow. The rst_n term keeps the request low while in reset.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + SW'(pipe_q[i]);
    end
    occupancy   = SW'(buf_count) + inflight;
    fifo_r_en   = rst_n && !fifo_rempty && (occupancy < SW'(BUF_DEPTH));
    accepted_rd = fifo_r_en && !fifo_rempty;
  end

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = accepted_rd;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  assign push = pipe_q[RD_LATENCY-1];
  assign pop  = m_valid && m_ready;

  fifo_rd_adapt_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (fifo_rdata),
    .pop_i       (pop),
    .head_o      (m_data),
    .count_o     (buf_count)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pop) begin
      if (col_q == CLW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RWW'(IMG_HEIGHT - 1)) ? '0 : row_q + RWW'(1);
      end else begin
        col_d = col_q + CLW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  assign m_valid = (buf_count != '0);
  assign m_sof   = m_valid && (col_q == '0) && (row_q == '0);
  assign m_eol   = m_valid && (col_q == CLW'(IMG_WIDTH - 1));

`ifdef FIFO_RD_ADAPT_STATS_EN
  logic [STATS_W-1:0] stall_cnt_q;
  logic [STATS_W-1:0] starve_cnt_q;

  // rst_n is implicitly high outside the reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      if (m_valid && !m_ready && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + STATS_W'(1);
      if (m_ready && !m_valid && (starve_cnt_q != '1))
        starve_cnt_q <= starve_cnt_q + STATS_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign starve_cnt = starve_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_line_buffer_rd_adapter.sv
// Directed self-checking bench for fifo_line_buffer_rd_adapter.
// Instance 0: default parameters (1-bit, RD_LATENCY=1, 640x480).
// Instance 1: 8-bit, RD_LATENCY=3, 4x2 frame.
module tb_fifo_line_buffer_rd_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic       gate  [2];
  logic       ready [2];
  int         avail [2];
  int         acc   [2];
  logic [7:0] dl    [2][3];

  logic       rempty0, rempty1, ren0, ren1, mv0, mv1, sof0, sof1, eol0, eol1;
  logic [0:0] md0;
  logic [7:0] md1;
  logic       r_en [2], mvalid [2], sof [2], eol [2], rempty [2];
  logic [7:0] mdata [2];

`ifdef FIFO_RD_ADAPT_STATS_EN
  logic [31:0] stall0, starve0, stall1, starve1;
`endif

  int passes = 0;
  int total  = 0;
  int nbeat [2];
  int eolcnt [2];
  int lasteol [2];
  logic [31:0] sofmask [2];
  logic [31:0] eolmask [2];
  logic        held [2];
  logic [7:0]  hdata [2];
  logic [1:0]  hmark [2];

  assign rempty0 = gate[0] || (acc[0] >= avail[0]);
  assign rempty1 = gate[1] || (acc[1] >= avail[1]);

  always_comb begin
    r_en[0]   = ren0;      r_en[1]   = ren1;
    mvalid[0] = mv0;       mvalid[1] = mv1;
    sof[0]    = sof0;      sof[1]    = sof1;
    eol[0]    = eol0;      eol[1]    = eol1;
    mdata[0]  = 8'(md0);   mdata[1]  = md1;
    rempty[0] = rempty0;   rempty[1] = rempty1;
  end

  function automatic logic [7:0] pix(input int n);
    return 8'(n * 37 + 5);
  endfunction

  function automatic int wid(input int k);
    return (k == 0) ? 640 : 4;
  endfunction

  function automatic int hgt(input int k);
    return (k == 0) ? 480 : 2;
  endfunction

  // FIFO + RAM model: sequential source data, fixed read latency per instance.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) acc[k] <= 0;
      else if (r_en[k] && !rempty[k]) acc[k] <= acc[k] + 1;
      dl[k][0] <= pix(acc[k]);
      dl[k][1] <= dl[k][0];
      dl[k][2] <= dl[k][1];
    end
  end

  fifo_line_buffer_rd_adapter u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n[0]),
    .fifo_rempty (rempty0),
    .fifo_r_en   (ren0),
    .fifo_rdata  (dl[0][0][0:0]),
    .m_valid     (mv0),
    .m_ready     (ready[0]),
    .m_data      (md0),
    .m_sof       (sof0),
    .m_eol       (eol0)
`ifdef FIFO_RD_ADAPT_STATS_EN
    ,
    .stall_cnt   (stall0),
    .starve_cnt  (starve0)
`endif
  );

  fifo_line_buffer_rd_adapter #(
    .DATA_WIDTH (8),
    .RD_LATENCY (3),
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (2)
  ) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n[1]),
    .fifo_rempty (rempty1),
    .fifo_r_en   (ren1),
    .fifo_rdata  (dl[1][2]),
    .m_valid     (mv1),
    .m_ready     (ready[1]),
    .m_data      (md1),
    .m_sof       (sof1),
    .m_eol       (eol1)
`ifdef FIFO_RD_ADAPT_STATS_EN
    ,
    .stall_cnt   (stall1),
    .starve_cnt  (starve1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else passes++;
  endtask

  // Sample both instances mid-cycle, score accepted beats and stall holds,
  // then advance one clock and return 1 time unit after the edge.
  task automatic tick();
    logic [7:0] p, e;
    int n, col, row;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (held[k] && mvalid[k]) begin
        chk($sformatf("u%0d_hold_data", k), mdata[k], hdata[k]);
        chk($sformatf("u%0d_hold_mark", k), {sof[k], eol[k]}, hmark[k]);
      end
      held[k] = 1'b0;
      if (mvalid[k] && ready[k]) begin
        n   = nbeat[k];
        p   = pix(n);
        e   = (k == 0) ? {7'b0, p[0]} : p;
        col = n % wid(k);
        row = (n / wid(k)) % hgt(k);
        chk($sformatf("u%0d_beat%0d_data", k, n), mdata[k], e);
        chk($sformatf("u%0d_beat%0d_sof", k, n), sof[k], (col == 0 && row == 0));
        chk($sformatf("u%0d_beat%0d_eol", k, n), eol[k], (col == wid(k) - 1));
        if (n < 32) begin
          if (sof[k]) sofmask[k][n] = 1'b1;
          if (eol[k]) eolmask[k][n] = 1'b1;
        end
        if (eol[k]) begin
          eolcnt[k]++;
          lasteol[k] = n + 1;
        end
        nbeat[k]++;
      end else if (mvalid[k]) begin
        held[k]  = 1'b1;
        hdata[k] = mdata[k];
        hmark[k] = {sof[k], eol[k]};
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats(input int k);
    nbeat[k] = 0; eolcnt[k] = 0; lasteol[k] = 0;
    sofmask[k] = '0; eolmask[k] = '0; held[k] = 1'b0;
  endtask

  task automatic do_reset(input int k);
    rst_n[k] = 1'b0; gate[k] = 1'b1; ready[k] = 1'b0; avail[k] = 0;
    clear_stats(k);
    tick();
    tick();
    rst_n[k] = 1'b1;
  endtask

  initial begin
    int lat, gaps, cyc, a0, maxocc;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; gate[k] = 1'b0; ready[k] = 1'b0; avail[k] = 5;
      clear_stats(k);
    end
    @(posedge clk);
    #1;
    tick();
    // Reset values, with the FIFO reporting data available.
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d_rst_r_en", k), r_en[k], 1'b0);
      chk($sformatf("u%0d_rst_valid", k), mvalid[k], 1'b0);
      chk($sformatf("u%0d_rst_data", k), mdata[k], 8'h00);
      chk($sformatf("u%0d_rst_sof_eol", k), {sof[k], eol[k]}, 2'b00);
    end
`ifdef FIFO_RD_ADAPT_STATS_EN
    chk("u0_rst_stall", stall0, 0);
    chk("u0_rst_starve", starve0, 0);
`endif
    gate[0] = 1'b1; gate[1] = 1'b1; avail[0] = 0; avail[1] = 0;
    tick();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Full 640-pixel line at 1 beat/cycle, RD_LATENCY=1.
    ready[0] = 1'b1; avail[0] = 640; gate[0] = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!mvalid[0] && lat < 20);
    chk("u0_first_latency", lat, 2);
    gaps = 0; cyc = 0;
    while (nbeat[0] < 640 && cyc < 2000) begin
      if (!mvalid[0]) gaps++;
      tick();
      cyc++;
    end
    chk("u0_line_beats", nbeat[0], 640);
    chk("u0_line_gaps", gaps, 0);
    chk("u0_line_eol_count", eolcnt[0], 1);
    chk("u0_line_eol_beat", lasteol[0], 640);
    chk("u0_line_sof_first", sofmask[0], 32'h1);

    // Stall: requests stop after BUF_DEPTH reads, nothing lost afterwards.
    ready[0] = 1'b0; avail[0] = 740; a0 = acc[0];
    for (int t = 0; t < 20; t++) tick();
    chk("u0_stall_reads", acc[0] - a0, 3);
    chk("u0_stall_r_en", r_en[0], 1'b0);
    chk("u0_stall_nopop", nbeat[0], 640);
    ready[0] = 1'b1; cyc = 0;
    while (nbeat[0] < 740 && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("u0_stall_drain", nbeat[0], 740);

    // 4x2 frame markers, RD_LATENCY=3.
    ready[1] = 1'b1; avail[1] = 16; gate[1] = 1'b0; cyc = 0;
    while (nbeat[1] < 16 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("u1_frame_beats", nbeat[1], 16);
    chk("u1_sof_mask", sofmask[1], 32'h0101);
    chk("u1_eol_mask", eolmask[1], 32'h8888);

    // Toggling empty flag and intermittent backpressure.
    avail[1] = acc[1] + 1000; maxocc = 0; a0 = acc[1];
    for (int t = 0; t < 60; t++) begin
      gate[1]  = ((t / 2) % 2) == 1;
      ready[1] = (t % 7) < 5;
      tick();
      if (acc[1] - nbeat[1] > maxocc) maxocc = acc[1] - nbeat[1];
    end
    gate[1] = 1'b1; ready[1] = 1'b1; cyc = 0;
    while (nbeat[1] != acc[1] && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("u1_toggle_drain", nbeat[1], acc[1]);
    chk("u1_toggle_occ_le5", (maxocc <= 5), 1'b1);
    chk("u1_toggle_progress", (acc[1] - a0 > 10), 1'b1);

    // Reset with two reads in flight.
    gate[1] = 1'b0; ready[1] = 1'b0;
    tick();
    tick();
    rst_n[1] = 1'b0;
    #1;
    chk("u1_async_rst_outs", {r_en[1], mvalid[1], sof[1], eol[1], mdata[1]}, 12'h000);
    @(posedge clk);
    #1;
    chk("u1_rst_edge_outs", {r_en[1], mvalid[1], sof[1], eol[1], mdata[1]}, 12'h000);
    clear_stats(1);
    avail[1] = 4; ready[1] = 1'b1; rst_n[1] = 1'b1; cyc = 0;
    while (!mvalid[1] && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("u1_post_rst_valid", mvalid[1], 1'b1);
    chk("u1_post_rst_sof", sof[1], 1'b1);
    chk("u1_post_rst_data", mdata[1], pix(0));
    cyc = 0;
    while (nbeat[1] < 4 && cyc < 30) begin
      tick();
      cyc++;
    end
    chk("u1_post_rst_beats", nbeat[1], 4);

`ifdef FIFO_RD_ADAPT_STATS_EN
    do_reset(0);
    ready[0] = 1'b1;
    for (int t = 0; t < 5; t++) tick();
    chk("u0_starve_cnt", starve0, 5);
    ready[0] = 1'b0; avail[0] = 1; gate[0] = 1'b0; cyc = 0;
    while (!mvalid[0] && cyc < 20) begin
      tick();
      cyc++;
    end
    for (int t = 0; t < 7; t++) tick();
    chk("u0_stall_cnt", stall0, 7);
    chk("u0_starve_held", starve0, 5);
    ready[0] = 1'b1;
    tick();
    tick();
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
